// File: rtl/conv_window_mac.sv
// Windowed 2-D convolution stage: latches one image and one filter on start, then
// streams one signed K*K multiply-accumulate per valid window position, row-major.
module conv_window_mac #(
  parameter int FILTER_DIM = 3,
  parameter int INPUT_DIM  = 5,
  parameter int STRIDE     = 1,
  parameter int WIDTH      = 4,
  localparam int OUT_DIM = (INPUT_DIM - FILTER_DIM) / STRIDE + 1,
  localparam int ACC_W   = 2 * WIDTH + $clog2(FILTER_DIM * FILTER_DIM),
  localparam int IDX_W   = (OUT_DIM > 1) ? $clog2(OUT_DIM) : 1
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   start,
  input  logic [FILTER_DIM*FILTER_DIM*WIDTH-1:0] filter,
  input  logic [INPUT_DIM*INPUT_DIM*WIDTH-1:0]   image,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic [ACC_W-1:0]                       out_data,
  output logic [IDX_W-1:0]                       out_row,
  output logic [IDX_W-1:0]                       out_col,
  output logic                                   busy,
  output logic                                   done
);

  localparam int K    = FILTER_DIM;
  localparam int TAPS = K * K;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(OUT_DIM - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, FINISH} state_t;

  state_t state, state_nxt;

  logic [INPUT_DIM*INPUT_DIM*WIDTH-1:0] img_lat;
  logic [TAPS*WIDTH-1:0]                flt_lat;
  logic [IDX_W-1:0]                     row, col;

  logic stall, en, accept, issue, last_pos, pipe_empty;

  logic signed [WIDTH-1:0]   band [K][INPUT_DIM];
  logic signed [WIDTH-1:0]   win  [TAPS];
  logic signed [ACC_W-1:0]   sum;

  logic                      s1_valid;
  logic signed [WIDTH-1:0]   s1_pix [TAPS];
  logic signed [WIDTH-1:0]   s1_wgt [TAPS];
  logic [IDX_W-1:0]          s1_row, s1_col;

  logic                      s2_valid;
  logic signed [2*WIDTH-1:0] s2_prod [TAPS];
  logic [IDX_W-1:0]          s2_row, s2_col;

  // Handshake and sequencing qualifiers; a stall freezes the whole datapath
  always_comb begin
    stall      = out_valid & ~out_ready;
    en         = ~stall;
    accept     = (state == IDLE) & start;
    issue      = (state == RUN) & en;
    last_pos   = (row == LAST) & (col == LAST);
    pipe_empty = ~s1_valid & ~s2_valid & (~out_valid | out_ready);
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN; else state_nxt = IDLE;
      RUN:     if (issue && last_pos) state_nxt = DRAIN; else state_nxt = RUN;
      DRAIN:   if (pipe_empty) state_nxt = FINISH; else state_nxt = DRAIN;
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register with registered busy/done decoded from the next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt == RUN) || (state_nxt == DRAIN);
      done  <= (state_nxt == FINISH);
    end
  end

  // Operand latch and row-major position counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      img_lat <= '0;
      flt_lat <= '0;
      row     <= '0;
      col     <= '0;
    end else if (accept) begin
      img_lat <= image;
      flt_lat <= filter;
      row     <= '0;
      col     <= '0;
    end else if (issue) begin
      if (col == LAST) begin
        col <= '0;
        row <= row + IDX_W'(1);
      end else begin
        col <= col + IDX_W'(1);
      end
    end
  end

  // Row selection: only constant offsets, so each output row becomes one mux leg
  always_comb begin
    for (int i = 0; i < K; i++)
      for (int c = 0; c < INPUT_DIM; c++)
        band[i][c] = '0;
    for (int p = 0; p < OUT_DIM; p++) begin
      if (row == IDX_W'(p)) begin
        for (int i = 0; i < K; i++)
          for (int c = 0; c < INPUT_DIM; c++)
            band[i][c] = img_lat[((p*STRIDE + i)*INPUT_DIM + c)*WIDTH +: WIDTH];
      end
    end
  end

  // Column selection out of the chosen row band
  always_comb begin
    for (int t = 0; t < TAPS; t++) win[t] = '0;
    for (int q = 0; q < OUT_DIM; q++) begin
      if (col == IDX_W'(q)) begin
        for (int i = 0; i < K; i++)
          for (int j = 0; j < K; j++)
            win[i*K + j] = band[i][q*STRIDE + j];
      end
    end
  end

  // Sign-extended adder tree feeding the output stage
  always_comb begin
    sum = '0;
    for (int t = 0; t < TAPS; t++) sum = sum + ACC_W'(s2_prod[t]);
  end

  // Three-stage pipeline: window capture, products, sum
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_row    <= '0;
      s1_col    <= '0;
      s2_valid  <= 1'b0;
      s2_row    <= '0;
      s2_col    <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_row   <= '0;
      out_col   <= '0;
      for (int t = 0; t < TAPS; t++) begin
        s1_pix[t]  <= '0;
        s1_wgt[t]  <= '0;
        s2_prod[t] <= '0;
      end
    end else if (en) begin
      s1_valid  <= issue;
      s1_row    <= row;
      s1_col    <= col;
      s2_valid  <= s1_valid;
      s2_row    <= s1_row;
      s2_col    <= s1_col;
      out_valid <= s2_valid;
      out_data  <= sum;
      out_row   <= s2_row;
      out_col   <= s2_col;
      for (int t = 0; t < TAPS; t++) begin
        s1_pix[t]  <= win[t];
        s1_wgt[t]  <= flt_lat[t*WIDTH +: WIDTH];
        s2_prod[t] <= (2*WIDTH)'(s1_pix[t]) * (2*WIDTH)'(s1_wgt[t]);
      end
    end
  end

endmodule

// File: tb/tb_conv_window_mac.sv
// Scoreboard bench for conv_window_mac: a stride-1 4-bit instance and a stride-2 8-bit
// instance, checked against a plain-arithmetic convolution model.
module tb_conv_window_mac;

  localparam int K = 3;
  localparam int N = 5;
  localparam int W1 = 4;
  localparam int W2 = 8;
  localparam int ACC1 = 12;
  localparam int ACC2 = 20;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic start2 = 1'b0;
  logic out_ready = 1'b1;

  logic [N*N*W1-1:0] image1 = '0;
  logic [K*K*W1-1:0] filter1 = '0;
  logic [N*N*W2-1:0] image2 = '0;
  logic [K*K*W2-1:0] filter2 = '0;

  logic            ov1, busy1, done1;
  logic [ACC1-1:0] d1;
  logic [1:0]      r1, c1;
  logic            ov2, busy2, done2;
  logic [ACC2-1:0] d2;
  logic [0:0]      r2, c2;

  always #5 clk = ~clk;

  conv_window_mac #(.FILTER_DIM(K), .INPUT_DIM(N), .STRIDE(1), .WIDTH(W1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .filter(filter1), .image(image1),
    .out_valid(ov1), .out_ready(out_ready), .out_data(d1), .out_row(r1), .out_col(c1),
    .busy(busy1), .done(done1));

  conv_window_mac #(.FILTER_DIM(K), .INPUT_DIM(N), .STRIDE(2), .WIDTH(W2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .filter(filter2), .image(image2),
    .out_valid(ov2), .out_ready(out_ready), .out_data(d2), .out_row(r2), .out_col(c2),
    .busy(busy2), .done(done2));

  typedef struct packed { int data; int row; int col; } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int tests = 0;
  int failed = 0;
  int img [N][N];
  int flt [K][K];
  int hs [2];
  int dones [2];
  int hs_base [2];
  int exp_n [2];
  bit stall_p [2];
  int dp [2], rp [2], cp [2];
  int ready_mode = 0;
  int run_id = 0;
  int bp_run = 0;
  int bpk = 0;

  task automatic chk(bit ok, string name, int act, int expv);
    tests++;
    if (!ok) begin
      failed++;
      $display("FAIL %s: actual=%0d expected=%0d (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Reference: plain dot product of the window at (r*s, c*s) with the filter
  function automatic int ref_mac(int s, int r, int c);
    int acc = 0;
    for (int i = 0; i < K; i++)
      for (int j = 0; j < K; j++)
        acc += img[r*s + i][c*s + j] * flt[i][j];
    return acc;
  endfunction

  task automatic mon(int inst, logic ov, int d, int r, int c, logic dn);
    exp_t e;
    int qs;
    if (!rst_n) begin
      stall_p[inst] = 1'b0;
      if (inst == 0) q0.delete(); else q1.delete();
      return;
    end
    if (stall_p[inst]) begin
      chk(ov == 1'b1, "stall_valid_hold", int'(ov), 1);
      chk(d == dp[inst] && r == rp[inst] && c == cp[inst], "stall_data_hold", d, dp[inst]);
    end
    if (ov && out_ready) begin
      hs[inst]++;
      qs = (inst == 0) ? q0.size() : q1.size();
      chk(qs > 0, "unexpected_result", qs, 1);
      if (qs > 0) begin
        if (inst == 0) e = q0.pop_front(); else e = q1.pop_front();
        chk(d == e.data, "out_data", d, e.data);
        chk(r == e.row, "out_row", r, e.row);
        chk(c == e.col, "out_col", c, e.col);
      end
    end
    stall_p[inst] = ov && !out_ready;
    dp[inst] = d;
    rp[inst] = r;
    cp[inst] = c;
    if (dn) begin
      dones[inst]++;
      chk(hs[inst] - hs_base[inst] == exp_n[inst], "done_after_last",
          hs[inst] - hs_base[inst], exp_n[inst]);
    end
  endtask

  always @(negedge clk) begin
    mon(0, ov1, int'($signed(d1)), int'(r1), int'(c1), done1);
    mon(1, ov2, int'($signed(d2)), int'(r2), int'(c2), done2);
  end

  // Downstream ready: always, random, or 5-low-then-toggle after the first valid
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      1: out_ready = 1'($urandom_range(0, 1));
      2: begin
        if (bp_run != run_id) begin
          bp_run = run_id;
          bpk = 0;
        end
        if (bpk == 0 && (ov1 || ov2)) bpk = 1;
        else if (bpk > 0) bpk++;
        out_ready = (bpk > 5) ? ~bpk[0] : 1'b0;
      end
      default: out_ready = 1'b1;
    endcase
  end

  task automatic load_ops();
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        image1[(r*N + c)*W1 +: W1] = W1'(img[r][c]);
        image2[(r*N + c)*W2 +: W2] = W2'(img[r][c]);
      end
    for (int i = 0; i < K; i++)
      for (int j = 0; j < K; j++) begin
        filter1[(i*K + j)*W1 +: W1] = W1'(flt[i][j]);
        filter2[(i*K + j)*W2 +: W2] = W2'(flt[i][j]);
      end
  endtask

  task automatic rand_ops(int lo, int hi);
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) img[r][c] = int'($urandom_range(0, hi - lo)) + lo;
    for (int i = 0; i < K; i++)
      for (int j = 0; j < K; j++) flt[i][j] = int'($urandom_range(0, hi - lo)) + lo;
  endtask

  task automatic push_expected(int inst);
    exp_t e;
    int od = (inst == 0) ? 3 : 2;
    int s = (inst == 0) ? 1 : 2;
    for (int r = 0; r < od; r++)
      for (int c = 0; c < od; c++) begin
        e.data = ref_mac(s, r, c);
        e.row = r;
        e.col = c;
        if (inst == 0) q0.push_back(e); else q1.push_back(e);
      end
    hs_base[inst] = hs[inst];
    exp_n[inst] = od * od;
  endtask

  task automatic issue_start(int inst);
    @(posedge clk); #1;
    if (inst == 0) start = 1'b1; else start2 = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    start2 = 1'b0;
  endtask

  task automatic run_job(int inst, int mode, bit inject);
    int od = (inst == 0) ? 3 : 2;
    int dn0, cyc, qs;
    load_ops();
    push_expected(inst);
    ready_mode = mode;
    run_id++;
    dn0 = dones[inst];
    issue_start(inst);
    chk(((inst == 0) ? busy1 : busy2) == 1'b1, "busy_after_start", 0, 1);
    if (inst == 0)
      for (int k = 1; k <= 3; k++) begin
        @(posedge clk); #1;
        chk(ov1 == (k == 3), "first_valid_latency", int'(ov1), int'(k == 3));
      end
    cyc = 0;
    while (dones[inst] == dn0 && cyc < 400) begin
      @(posedge clk); #1;
      cyc++;
      if (inject && cyc == 2) begin
        start = 1'b1;
        for (int t = 0; t < N*N; t++) image1[t*W1 +: W1] = 4'($urandom_range(0, 15));
        for (int t = 0; t < K*K; t++) filter1[t*W1 +: W1] = 4'($urandom_range(0, 15));
      end else if (inject && cyc == 3) begin
        start = 1'b0;
      end
    end
    chk(dones[inst] != dn0, "done_timeout", cyc, 400);
    repeat (3) @(posedge clk);
    #1;
    qs = (inst == 0) ? q0.size() : q1.size();
    chk(dones[inst] - dn0 == 1, "done_pulses", dones[inst] - dn0, 1);
    chk(hs[inst] - hs_base[inst] == od * od, "handshake_count", hs[inst] - hs_base[inst], od * od);
    chk(qs == 0, "results_missing", qs, 0);
    chk(((inst == 0) ? busy1 : busy2) == 1'b0, "busy_after_done", 1, 0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk(ov1 == 1'b0 && ov2 == 1'b0, "reset_out_valid", int'(ov1), 0);
    chk(busy1 == 1'b0 && done1 == 1'b0, "reset_busy_done", int'(busy1), 0);
    chk(d1 == '0 && r1 == '0 && c1 == '0, "reset_outputs", int'(d1), 0);
    rst_n = 1'b1;

    // All ones: every window sums to 9
    for (int r = 0; r < N; r++) for (int c = 0; c < N; c++) img[r][c] = 1;
    for (int i = 0; i < K; i++) for (int j = 0; j < K; j++) flt[i][j] = 1;
    run_job(0, 0, 1'b0);

    // Pixel = row index, centre tap only
    for (int r = 0; r < N; r++) for (int c = 0; c < N; c++) img[r][c] = r;
    for (int i = 0; i < K; i++) for (int j = 0; j < K; j++) flt[i][j] = (i == 1 && j == 1) ? 1 : 0;
    run_job(0, 0, 1'b0);

    // Most negative operands: 9 * 64 = 576
    for (int r = 0; r < N; r++) for (int c = 0; c < N; c++) img[r][c] = -8;
    for (int i = 0; i < K; i++) for (int j = 0; j < K; j++) flt[i][j] = -8;
    run_job(0, 0, 1'b0);

    rand_ops(-8, 7);
    run_job(0, 2, 1'b0);
    for (int n = 0; n < 3; n++) begin
      rand_ops(-8, 7);
      run_job(0, 1, 1'b0);
    end

    // Stride 2: pixel 5r+c, top-left tap -> 0, 2, 10, 12
    for (int r = 0; r < N; r++) for (int c = 0; c < N; c++) img[r][c] = 5*r + c;
    for (int i = 0; i < K; i++) for (int j = 0; j < K; j++) flt[i][j] = (i == 0 && j == 0) ? 1 : 0;
    run_job(1, 0, 1'b0);
    rand_ops(-128, 127);
    run_job(1, 1, 1'b0);

    // Start pulsed mid-run with new operands must be ignored
    rand_ops(-8, 7);
    run_job(0, 0, 1'b1);

    // Reset mid-run, then a clean run
    begin
      int dn0;
      rand_ops(-8, 7);
      load_ops();
      push_expected(0);
      ready_mode = 0;
      run_id++;
      dn0 = dones[0];
      issue_start(0);
      repeat (5) @(posedge clk);
      #1;
      chk(ov1 == 1'b1, "valid_before_reset", int'(ov1), 1);
      rst_n = 1'b0;
      #1;
      chk(ov1 == 1'b0, "reset_drops_valid", int'(ov1), 0);
      chk(busy1 == 1'b0, "reset_drops_busy", int'(busy1), 0);
      chk(done1 == 1'b0 && d1 == '0 && r1 == '0 && c1 == '0, "reset_clears_outputs", int'(d1), 0);
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      chk(dones[0] == dn0, "no_done_after_reset", dones[0] - dn0, 0);
      chk(ov1 == 1'b0 && busy1 == 1'b0, "idle_after_reset", int'(busy1), 0);
      rand_ops(-8, 7);
      run_job(0, 1, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
